// File: rtl/basic_system_ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// One command per cycle reaches the RAM; read data returns one clock after acceptance.
module basic_system_ram_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,

    output logic [ADDR_W-1:0]     ram_address,
    output logic [DATA_W/8-1:0]   ram_byteenable,
    output logic [DATA_W-1:0]     ram_writedata,
    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic                  ram_clken,
    input  logic [DATA_W-1:0]     ram_readdata
);

    // Handshake: a requester's command is taken on a clock edge where it is
    // active (read or write high) and its waitrequest is low; otherwise it holds.

    logic run_q;
    logic last_grant_q, last_grant_d;
    logic rd_pending_q, rd_pending_d;
    logic rd_owner_q,   rd_owner_d;

    logic m0_act, m1_act;
    logic grant_vld;
    logic grant_idx;
    logic win_read;
    logic win_write;

    // run_q keeps the arbiter and RAM clock enable off until the first edge after release.
    always_comb begin
        m0_act    = m0_read | m0_write;
        m1_act    = m1_read | m1_write;
        grant_vld = run_q & (m0_act | m1_act);
        if (m0_act && m1_act) begin
            grant_idx = ~last_grant_q;
        end else begin
            grant_idx = m1_act;
        end
    end

    always_comb begin
        ram_address    = grant_idx ? m1_address    : m0_address;
        ram_byteenable = grant_idx ? m1_byteenable : m0_byteenable;
        ram_writedata  = grant_idx ? m1_writedata  : m0_writedata;
        win_read       = grant_idx ? m1_read       : m0_read;
        win_write      = grant_idx ? m1_write      : m0_write;
        ram_chipselect = grant_vld;
        ram_write      = grant_vld & win_write;
        ram_clken      = run_q;

        m0_waitrequest = m0_act & ~(grant_vld & ~grant_idx);
        m1_waitrequest = m1_act & ~(grant_vld &  grant_idx);

        last_grant_d = grant_vld ? grant_idx : last_grant_q;
        rd_pending_d = grant_vld & win_read;
        rd_owner_d   = (grant_vld & win_read) ? grant_idx : rd_owner_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q        <= 1'b0;
            last_grant_q <= 1'b1;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= 1'b0;
        end else begin
            run_q        <= 1'b1;
            last_grant_q <= last_grant_d;
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    // The RAM output is shared; each requester qualifies it with its own valid.
    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;
    assign m0_readdatavalid = rd_pending_q & ~rd_owner_q;
    assign m1_readdatavalid = rd_pending_q &  rd_owner_q;

endmodule

// File: tb/tb_basic_system_ram_arbiter.sv
// Bench for basic_system_ram_arbiter: behavioural RAM, round-robin reference model,
// per-requester expected read queues drained by an independent monitor.
module tb_basic_system_ram_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] m0_address, m1_address;
    logic [BW-1:0] m0_byteenable, m1_byteenable;
    logic          m0_read, m0_write, m1_read, m1_write;
    logic [DW-1:0] m0_writedata, m1_writedata;
    logic          m0_waitrequest, m1_waitrequest;
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic [AW-1:0] ram_address;
    logic [BW-1:0] ram_byteenable;
    logic [DW-1:0] ram_writedata;
    logic          ram_chipselect, ram_write, ram_clken;
    logic [DW-1:0] ram_readdata;

    basic_system_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_writedata(ram_writedata), .ram_chipselect(ram_chipselect),
        .ram_write(ram_write), .ram_clken(ram_clken), .ram_readdata(ram_readdata)
    );

    // Synchronous single-port RAM with byte enables and one-cycle read latency.
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    logic [DW-1:0] ram_q = '0;
    logic [DW-1:0] ram_w;
    always @(posedge clk) begin
        if (ram_clken && ram_chipselect) begin
            if (ram_write) begin
                ram_w = ram_mem[ram_address];
                for (int b = 0; b < BW; b++)
                    if (ram_byteenable[b]) ram_w[8*b +: 8] = ram_writedata[8*b +: 8];
                ram_mem[ram_address] <= ram_w;
            end else begin
                ram_q <= ram_mem[ram_address];
            end
        end
    end
    assign ram_readdata = ram_q;

    // Reference state and scoreboard
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            ref_last;
    logic [DW-1:0] exp0_q[$], exp1_q[$];
    int            due0_q[$], due1_q[$];
    int checks = 0, errors = 0, cyc = 0;
    int g0 = 0, g1 = 0, vcnt0 = 0, vcnt1 = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic set_cmd(input int r, input logic rd, input logic wr, input logic [AW-1:0] a,
                           input logic [BW-1:0] be, input logic [DW-1:0] d);
        if (r == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
        end
    endtask

    task automatic idle(input int r);
        set_cmd(r, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // Called right after inputs are driven at a negedge; checks the cycle, then moves to the next negedge.
    task automatic cycle_check(output bit acc0, output bit acc1);
        bit a0, a1, gv, wr;
        int win;
        logic [AW-1:0] a;
        #1;
        a0  = m0_read | m0_write;
        a1  = m1_read | m1_write;
        gv  = a0 | a1;
        win = (a0 && a1) ? 1 - ref_last : (a1 ? 1 : 0);
        g0 += int'(a0 && !m0_waitrequest);
        g1 += int'(a1 && !m1_waitrequest);
        check("m0_waitrequest", m0_waitrequest, a0 && !(gv && win == 0));
        check("m1_waitrequest", m1_waitrequest, a1 && !(gv && win == 1));
        check("ram_chipselect", ram_chipselect, gv);
        check("ram_clken", ram_clken, 1);
        if (gv) begin
            a  = (win == 1) ? m1_address : m0_address;
            wr = (win == 1) ? m1_write : m0_write;
            check("ram_address", ram_address, a);
            check("ram_write", ram_write, wr);
            ref_last = win;
            if (wr) begin
                if (win == 1) ref_mem[a] = merge(ref_mem[a], m1_writedata, m1_byteenable);
                else          ref_mem[a] = merge(ref_mem[a], m0_writedata, m0_byteenable);
                check("ram_writedata", ram_writedata, (win == 1) ? m1_writedata : m0_writedata);
            end else if (win == 0) begin
                exp0_q.push_back(ref_mem[a]); due0_q.push_back(cyc + 1);
            end else begin
                exp1_q.push_back(ref_mem[a]); due1_q.push_back(cyc + 1);
            end
        end else begin
            check("ram_write_idle", ram_write, 0);
        end
        acc0 = gv && win == 0;
        acc1 = gv && win == 1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle(0); idle(1);
        reset_n = 1'b0;
        exp0_q.delete(); due0_q.delete(); exp1_q.delete(); due1_q.delete();
        ref_last = 1;
        #1;
        check("rst_chipselect", ram_chipselect, 0);
        check("rst_write", ram_write, 0);
        check("rst_clken", ram_clken, 0);
        check("rst_m0_valid", m0_readdatavalid, 0);
        check("rst_m1_valid", m1_readdatavalid, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic monitor_one(input int r);
        logic v;
        v = (r == 0) ? m0_readdatavalid : m1_readdatavalid;
        if (r == 0) begin
            while (due0_q.size() > 0 && due0_q[0] < cyc) begin
                checks++; errors++;
                $display("FAIL m0_missing_valid: due cycle %0d, now %0d", due0_q[0], cyc);
                void'(due0_q.pop_front()); void'(exp0_q.pop_front());
            end
        end else begin
            while (due1_q.size() > 0 && due1_q[0] < cyc) begin
                checks++; errors++;
                $display("FAIL m1_missing_valid: due cycle %0d, now %0d", due1_q[0], cyc);
                void'(due1_q.pop_front()); void'(exp1_q.pop_front());
            end
        end
        if (v) begin
            if (r == 0) begin
                vcnt0++;
                if (exp0_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL m0_unexpected_valid: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    check("m0_latency", 64'(due0_q.pop_front()), 64'(cyc));
                    check("m0_readdata", m0_readdata, exp0_q.pop_front());
                end
            end else begin
                vcnt1++;
                if (exp1_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL m1_unexpected_valid: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    check("m1_latency", 64'(due1_q.pop_front()), 64'(cyc));
                    check("m1_readdata", m1_readdata, exp1_q.pop_front());
                end
            end
        end
    endtask

    always begin
        @(negedge clk);
        #2;
        monitor_one(0);
        monitor_one(1);
    end

    initial begin
        bit acc0, acc1, pend0, pend1;
        int k, v1_start;
        logic [DW-1:0] rv;
        logic [AW-1:0] ra;
        for (int i = 0; i < (1 << AW); i++) begin
            rv = $urandom;
            ram_mem[i] = rv;
            ref_mem[i] = rv;
        end
        ram_mem[5] = 32'hA5A5_0005; ref_mem[5] = 32'hA5A5_0005;
        ram_mem[6] = 32'h5A5A_0006; ref_mem[6] = 32'h5A5A_0006;
        idle(0); idle(1);
        @(negedge clk);
        do_reset();

        // Simultaneous reads straight out of reset: m0 first, then m1.
        set_cmd(0, 1, 0, 10'h005, 4'hF, '0);
        set_cmd(1, 1, 0, 10'h006, 4'hF, '0);
        cycle_check(acc0, acc1);
        check("tie_first_m0", acc0, 1);
        idle(0);
        cycle_check(acc0, acc1);
        check("second_m1", acc1, 1);
        idle(1);
        repeat (2) cycle_check(acc0, acc1);

        // m1 writes, m0 reads back.
        set_cmd(1, 0, 1, 10'h3FF, 4'hF, 32'hDEAD_BEEF);
        cycle_check(acc0, acc1);
        idle(1);
        set_cmd(0, 1, 0, 10'h3FF, 4'hF, '0);
        cycle_check(acc0, acc1);
        #2;
        check("wr_readback", m0_readdata, 32'hDEAD_BEEF);
        idle(0);
        cycle_check(acc0, acc1);

        // Partial byte-enable write.
        set_cmd(0, 0, 1, 10'h020, 4'hF, 32'h1122_3344);
        cycle_check(acc0, acc1);
        set_cmd(0, 0, 1, 10'h020, 4'h2, 32'h0000_AB00);
        cycle_check(acc0, acc1);
        set_cmd(0, 1, 0, 10'h020, 4'hF, '0);
        cycle_check(acc0, acc1);
        #2;
        check("be_merge", m0_readdata, 32'h1122_AB44);
        idle(0);
        cycle_check(acc0, acc1);

        // Continuous contention for 8 cycles.
        do_reset();
        g0 = 0; g1 = 0;
        for (int i = 0; i < 8; i++) begin
            set_cmd(0, 1, 0, AW'(i), 4'hF, '0);
            set_cmd(1, 1, 0, AW'(i + 16), 4'hF, '0);
            cycle_check(acc0, acc1);
        end
        check("contention_m0_grants", 64'(g0), 4);
        check("contention_m1_grants", 64'(g1), 4);
        idle(0); idle(1);
        repeat (2) cycle_check(acc0, acc1);

        // m1 alone, five back-to-back reads.
        v1_start = vcnt1;
        for (int i = 0; i < 5; i++) begin
            set_cmd(1, 1, 0, AW'(i + 40), 4'hF, '0);
            cycle_check(acc0, acc1);
        end
        idle(1);
        repeat (2) cycle_check(acc0, acc1);
        check("m1_solo_valids", 64'(vcnt1 - v1_start), 5);

        // Reset in the cycle after a granted read discards it; next tie goes to m0.
        set_cmd(0, 1, 0, 10'h005, 4'hF, '0);
        cycle_check(acc0, acc1);
        do_reset();
        set_cmd(0, 1, 0, 10'h007, 4'hF, '0);
        set_cmd(1, 1, 0, 10'h008, 4'hF, '0);
        cycle_check(acc0, acc1);
        check("post_reset_tie_m0", acc0, 1);
        idle(0);
        cycle_check(acc0, acc1);
        idle(1);

        // Randomized traffic; non-accepted commands are held.
        pend0 = 0; pend1 = 0;
        for (int n = 0; n < 400; n++) begin
            for (int r = 0; r < 2; r++) begin
                if ((r == 0 && !pend0) || (r == 1 && !pend1)) begin
                    k  = $urandom_range(0, 9);
                    ra = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, (1 << AW) - 1))
                                                     : AW'($urandom_range(0, 15));
                    if (k <= 2) idle(r);
                    else if (k <= 6) set_cmd(r, 1, 0, ra, BW'($urandom_range(0, 15)), '0);
                    else set_cmd(r, 0, 1, ra, BW'($urandom_range(0, 15)), $urandom);
                    if (r == 0) pend0 = (k > 2); else pend1 = (k > 2);
                end
            end
            cycle_check(acc0, acc1);
            if (acc0) pend0 = 0;
            if (acc1) pend1 = 0;
        end
        idle(0); idle(1);
        repeat (3) cycle_check(acc0, acc1);
        check("drain_m0", 64'(exp0_q.size()), 0);
        check("drain_m1", 64'(exp1_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/basic_system_ram_arbiter.md
BASIC_SYSTEM_RAM_ARBITER -- requirements
Module: basic_system_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width of the shared RAM port.
REQ-002 Parameter DATA_W, default 32, data width; byteenable width is DATA_W/8.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 reset_n  in  1  reset, asynchronous and active-low.
REQ-005 m0_address, m0_byteenable, m0_read, m0_write, m0_writedata  in  ADDR_W/DATA_W/8/1/1/DATA_W  requester 0 command.
REQ-006 m0_waitrequest  out  1  requester 0 command not accepted this cycle.
REQ-007 m0_readdata  out  DATA_W  requester 0 read data.
REQ-008 m0_readdatavalid  out  1  requester 0 read data valid.
REQ-009 m1_* ports, identical to REQ-005..REQ-008, for requester 1.
REQ-010 ram_address, ram_byteenable, ram_writedata  out  ADDR_W/DATA_W/8/DATA_W  shared RAM port command.
REQ-011 ram_chipselect, ram_write, ram_clken  out  1 each  RAM strobes.
REQ-012 ram_readdata  in  DATA_W  RAM output, valid one clk after the read command.

Function
REQ-013 A requester is active when its read or write is high; read and write high together on one requester is illegal and not checked.
REQ-014 Each cycle at most one requester is granted; grant is combinational from the current requests and the last_grant register.
REQ-015 One active requester: it is granted.
REQ-016 Both active: the requester not equal to last_grant is granted (round-robin).
REQ-017 last_grant updates to the granted index at the clk edge ending a grant cycle; with no grant it holds.
REQ-018 The granted requester sees waitrequest=0; a non-granted active requester sees waitrequest=1 and holds its command.
REQ-019 An idle requester sees waitrequest=0.
REQ-020 In a grant cycle, ram_address/byteenable/writedata are the winner's, ram_chipselect=1, and ram_write = winner's write.
REQ-021 With no grant: ram_chipselect=0, ram_write=0; address/data are don't-care.
REQ-022 ram_clken is constant 1 out of reset.
REQ-023 A granted read loads rd_pending=1 and rd_owner=winner index; otherwise rd_pending=0 next cycle.
REQ-024 mX_readdatavalid = rd_pending AND rd_owner==X; exactly one cycle per accepted read; read latency is exactly 1 clk after acceptance.
REQ-025 m0_readdata and m1_readdata both carry ram_readdata; the data is meaningful only with the corresponding readdatavalid.
REQ-026 A granted write produces no readdatavalid.
REQ-027 Back-to-back reads are accepted every cycle; throughput is 1 command/cycle total.
REQ-028 Under continuous contention, grants alternate 0,1,0,1; starvation is limited to 1 cycle.

Reset
REQ-029 While reset_n=0: last_grant=1 (so requester 0 wins the first tie), rd_pending=0, rd_owner=0, ram_chipselect=0, ram_write=0, ram_clken=0, both readdatavalid=0.
REQ-030 Asserting reset_n mid-read discards the pending read; no readdatavalid is produced for it after release.
REQ-031 Deassertion is sampled on clk; the first grant can occur in the first cycle after release.

Verification
REQ-032 After reset, m0 and m1 both read addr 0x005 and 0x006 in the same cycle -> cycle 1 grants m0 (m1 waitrequest=1); cycle 2 grants m1; m0_readdatavalid in cycle 2 and m1_readdatavalid in cycle 3 with the preloaded words.
REQ-033 m1 writes 0xDEADBEEF, byteenable 0xF, addr 0x3FF, then m0 reads 0x3FF -> m0 receives 0xDEADBEEF; no readdatavalid for the write.
REQ-034 Byteenable 0x2 write of 0x0000AB00 over 0x11223344 -> readback 0x1122AB44.
REQ-035 Both requesters hold reads for 8 cycles -> grants alternate exactly, 4 each; each readdatavalid arrives 1 cycle after its grant.
REQ-036 reset_n pulsed low in the cycle after a granted read -> no readdatavalid; outputs at their REQ-029 values; next tie grants m0.
REQ-037 Only m1 is active for 5 consecutive reads -> m1 waitrequest=0 throughout, 5 consecutive readdatavalid pulses.
